// File: rtl/output_drain_if.sv
// Stream bundle between the output drain controller, the convolution output
// FIFO (read side) and the packed-word consumer.
// The master modport is the drain controller.
// The slave modport is the FIFO/consumer side.
interface output_drain_if #(
   parameter int W    = 8,
   parameter int PACK = 4
);
   logic                fifo_valid;
   logic                fifo_rd_en;
   logic [W-1:0]        fifo_rd_data;
   logic [W*PACK-1:0]   out_data;
   logic                out_valid;
   logic                out_ready;
   logic                out_last;

   modport master (
      input  fifo_valid,
      input  fifo_rd_data,
      input  out_ready,
      output fifo_rd_en,
      output out_data,
      output out_valid,
      output out_last
   );

   modport slave (
      output fifo_valid,
      output fifo_rd_data,
      output out_ready,
      input  fifo_rd_en,
      input  out_data,
      input  out_valid,
      input  out_last
   );
endinterface

// File: rtl/output_drain_ctrl.sv
// Output drain controller: pulls frame_len pixels from the convolution output
// FIFO one at a time and packs them little-endian into W*PACK-bit words.
// Each word is presented on a valid/ready stream, and the final word of the
// frame is flagged with out_last.
// Optional stall watchdog: define OUTPUT_DRAIN_TIMEOUT_EN to build it.
module output_drain_ctrl #(
   parameter int W              = 8,
   parameter int PACK           = 4,
   parameter int LEN_W          = 16,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] frame_len,
   output_drain_if.master   bus,
   output logic             busy,
   output logic             done,
   output logic [LEN_W-1:0] words_sent,
   output logic             timeout_err
);
   localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_READ    = 3'd1;
   localparam logic [2:0] S_CAPTURE = 3'd2;
   localparam logic [2:0] S_EMIT    = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [LEN_W-1:0]  remaining_q, remaining_d;
   logic [LANE_W-1:0] lane_q, lane_d;
   logic [W*PACK-1:0] pack_q, pack_d;
   logic [LEN_W-1:0]  words_q, words_d;
   logic              fifo_rd_en_s;
   logic              stall_inc_s;
   logic              start_ok_s;

`ifdef OUTPUT_DRAIN_TIMEOUT_EN
   localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [STALL_W-1:0] stall_q, stall_d;
   logic               timeout_err_q, timeout_err_d;
`endif

   // Next-state, packing and counter logic for the drain FSM.
   always_comb begin
      state_d      = state_q;
      remaining_d  = remaining_q;
      lane_d       = lane_q;
      pack_d       = pack_q;
      words_d      = words_q;
      fifo_rd_en_s = 1'b0;
      stall_inc_s  = 1'b0;
      start_ok_s   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               start_ok_s  = 1'b1;
               remaining_d = frame_len;
               lane_d      = '0;
               pack_d      = '0;
               words_d     = '0;
               if (frame_len == {LEN_W{1'b0}}) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_READ;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_READ: begin
            // Read strobe is gated by fifo_valid so an empty FIFO is never read.
            fifo_rd_en_s = bus.fifo_valid;
            if (bus.fifo_valid) begin
               state_d = S_CAPTURE;
            end else begin
               stall_inc_s = 1'b1;
            end
         end
         S_CAPTURE: begin
            pack_d[int'(lane_q) * W +: W] = bus.fifo_rd_data;
            remaining_d = remaining_q - {{(LEN_W-1){1'b0}}, 1'b1};
            lane_d      = lane_q + {{(LANE_W-1){1'b0}}, 1'b1};
            if ((lane_q == LANE_W'(PACK - 1)) || (remaining_d == {LEN_W{1'b0}})) begin
               state_d = S_EMIT;
            end else begin
               state_d = S_READ;
            end
         end
         S_EMIT: begin
            if (bus.out_ready) begin
               words_d = words_q + {{(LEN_W-1){1'b0}}, 1'b1};
               pack_d  = '0;
               lane_d  = '0;
               if (remaining_q == {LEN_W{1'b0}}) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_READ;
               end
            end else begin
               stall_inc_s = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
`ifdef OUTPUT_DRAIN_TIMEOUT_EN
      timeout_err_d = timeout_err_q;
      stall_d       = '0;
      if (start_ok_s) begin
         timeout_err_d = 1'b0;
      end else begin
         timeout_err_d = timeout_err_q;
      end
      // Any cycle without a stall counts as progress and restarts the count.
      if (stall_inc_s) begin
         if (stall_q == STALL_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_err_d = 1'b1;
            state_d       = S_DONE;
            remaining_d   = '0;
            pack_d        = '0;
            lane_d        = '0;
            stall_d       = '0;
         end else begin
            stall_d = stall_q + {{(STALL_W-1){1'b0}}, 1'b1};
         end
      end else begin
         stall_d = '0;
      end
`endif
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         remaining_q <= '0;
         lane_q      <= '0;
         pack_q      <= '0;
         words_q     <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         lane_q      <= lane_d;
         pack_q      <= pack_d;
         words_q     <= words_d;
      end
   end

`ifdef OUTPUT_DRAIN_TIMEOUT_EN
   // Stall watchdog registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q       <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         stall_q       <= stall_d;
         timeout_err_q <= timeout_err_d;
      end
   end
   assign timeout_err = timeout_err_q;
`else
   logic unused_stall_s;
   assign unused_stall_s = stall_inc_s ^ start_ok_s ^ (TIMEOUT_CYCLES == 32'd0);
   assign timeout_err    = 1'b0;
`endif

   assign bus.fifo_rd_en = fifo_rd_en_s;
   assign bus.out_data   = pack_q;
   assign bus.out_valid  = (state_q == S_EMIT);
   assign bus.out_last   = (state_q == S_EMIT) && (remaining_q == {LEN_W{1'b0}});
   assign busy           = (state_q == S_READ) || (state_q == S_CAPTURE) || (state_q == S_EMIT);
   assign done           = (state_q == S_DONE);
   assign words_sent     = words_q;
endmodule

// File: tb/tb_output_drain_ctrl.sv
// Directed bench for output_drain_ctrl with a small behavioural FIFO whose
// read data is registered one cycle after fifo_rd_en.
module tb_output_drain_ctrl;
`ifdef OUTPUT_DRAIN_TIMEOUT_EN
   localparam int TO  = 16;
   localparam int GAP = 10;
`else
   localparam int TO  = 4096;
   localparam int GAP = 20;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] frame_len = 16'd0;
   logic        busy, done, timeout_err;
   logic [15:0] words_sent;

   logic [7:0]  mem [0:255];
   int          wr_ptr = 0;
   int          rd_ptr = 0;
   logic [7:0]  rd_data = 8'd0;

   int n_assert = 0;
   int n_fail   = 0;

   output_drain_if #(.W(8), .PACK(4)) bus ();

   output_drain_ctrl #(.W(8), .PACK(4), .LEN_W(16), .TIMEOUT_CYCLES(TO)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .frame_len   (frame_len),
      .bus         (bus.master),
      .busy        (busy),
      .done        (done),
      .words_sent  (words_sent),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   assign bus.fifo_valid   = (wr_ptr != rd_ptr);
   assign bus.fifo_rd_data = rd_data;

   // FIFO read side: registered data one cycle after the strobe.
   always @(posedge clk) begin
      if (bus.fifo_rd_en) begin
         rd_data <= mem[rd_ptr % 256];
         rd_ptr  <= rd_ptr + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      mem[wr_ptr % 256] = b;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic pulse_start(input logic [15:0] len);
      start     = 1'b1;
      frame_len = len;
      @(negedge clk);
      start     = 1'b0;
      frame_len = 16'd0;
   endtask

   task automatic wait_valid(input int max, output int cyc);
      cyc = 0;
      while (!bus.out_valid && cyc < max) begin
         @(negedge clk);
         cyc++;
      end
      check("valid_seen", {31'd0, bus.out_valid}, 32'd1);
   endtask

   initial begin
      int cyc;
      int base;
      logic seen;
      logic stable;
      logic [31:0] held;

      bus.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_last",  {31'd0, bus.out_last},  32'd0);
      check("rst_busy",  {31'd0, busy},          32'd0);
      check("rst_done",  {31'd0, done},          32'd0);
      check("rst_data",  bus.out_data,           32'd0);
      check("rst_words", {16'd0, words_sent},    32'd0);
      check("rst_tmo",   {31'd0, timeout_err},   32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Full word, single-word frame.
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      base = rd_ptr;
      pulse_start(16'd4);
      check("t1_busy", {31'd0, busy}, 32'd1);
      wait_valid(50, cyc);
      check("t1_latency", cyc, 32'd8);
      check("t1_data", bus.out_data, 32'h44332211);
      check("t1_last", {31'd0, bus.out_last}, 32'd1);
      @(negedge clk);
      check("t1_done",  {31'd0, done},       32'd1);
      check("t1_busy0", {31'd0, busy},       32'd0);
      check("t1_words", {16'd0, words_sent}, 32'd1);
      check("t1_reads", rd_ptr - base,       32'd4);
      @(negedge clk);
      check("t1_done_pulse", {31'd0, done}, 32'd0);

      // Six pixels: one full word then a partial word.
      for (int i = 1; i <= 6; i++) push(8'(i));
      base = rd_ptr;
      pulse_start(16'd6);
      wait_valid(50, cyc);
      check("t2_w0",    bus.out_data, 32'h04030201);
      check("t2_last0", {31'd0, bus.out_last}, 32'd0);
      @(negedge clk);
      wait_valid(50, cyc);
      check("t2_w1",    bus.out_data, 32'h00000605);
      check("t2_last1", {31'd0, bus.out_last}, 32'd1);
      @(negedge clk);
      check("t2_done",  {31'd0, done},       32'd1);
      check("t2_words", {16'd0, words_sent}, 32'd2);
      check("t2_reads", rd_ptr - base,       32'd6);

      // FIFO empty for a while after start.
      @(negedge clk);
      base = rd_ptr;
      seen = 1'b0;
      pulse_start(16'd4);
      for (int i = 0; i < GAP; i++) begin
         if (bus.fifo_rd_en) seen = 1'b1;
         @(negedge clk);
      end
      check("t3_no_rd", {31'd0, seen}, 32'd0);
      check("t3_busy",  {31'd0, busy}, 32'd1);
      push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
      wait_valid(50, cyc);
      check("t3_data", bus.out_data, 32'hA4A3A2A1);
      check("t3_reads", rd_ptr - base, 32'd4);
      @(negedge clk);
      @(negedge clk);

      // Consumer back-pressure during EMIT.
      bus.out_ready = 1'b0;
      push(8'h5A); push(8'h6B); push(8'h7C); push(8'h8D);
      pulse_start(16'd4);
      wait_valid(50, cyc);
      held   = bus.out_data;
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (!bus.out_valid || !bus.out_last || bus.out_data !== held) stable = 1'b0;
         @(negedge clk);
      end
      check("t4_stable", {31'd0, stable}, 32'd1);
      check("t4_data", held, 32'h8D7C6B5A);
      check("t4_words_hold", {16'd0, words_sent}, 32'd0);
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("t4_done",  {31'd0, done},          32'd1);
      check("t4_words", {16'd0, words_sent},    32'd1);
      check("t4_valid", {31'd0, bus.out_valid}, 32'd0);
      @(negedge clk);

      // Zero-length frame.
      base = rd_ptr;
      pulse_start(16'd0);
      check("t5_done",  {31'd0, done},          32'd1);
      check("t5_valid", {31'd0, bus.out_valid}, 32'd0);
      check("t5_busy",  {31'd0, busy},          32'd0);
      check("t5_words", {16'd0, words_sent},    32'd0);
      check("t5_reads", rd_ptr - base,          32'd0);
      @(negedge clk);

      // Second start while busy is ignored.
      push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
      pulse_start(16'd4);
      pulse_start(16'd2);
      wait_valid(50, cyc);
      check("t5b_data", bus.out_data, 32'hC4C3C2C1);
      check("t5b_last", {31'd0, bus.out_last}, 32'd1);
      @(negedge clk);
      check("t5b_words", {16'd0, words_sent}, 32'd1);
      @(negedge clk);

      // Reset mid-word; unread pixels stay in the FIFO.
      push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4);
      pulse_start(16'd4);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("t6_valid", {31'd0, bus.out_valid},  32'd0);
      check("t6_last",  {31'd0, bus.out_last},   32'd0);
      check("t6_busy",  {31'd0, busy},           32'd0);
      check("t6_done",  {31'd0, done},           32'd0);
      check("t6_data",  bus.out_data,            32'd0);
      check("t6_words", {16'd0, words_sent},     32'd0);
      check("t6_rden",  {31'd0, bus.fifo_rd_en}, 32'd0);
      check("t6_kept",  wr_ptr - rd_ptr,         32'd2);
      rst = 1'b0;
      @(negedge clk);
      pulse_start(16'd2);
      wait_valid(50, cyc);
      check("t6_data2", bus.out_data, 32'h0000B4B3);
      check("t6_last2", {31'd0, bus.out_last}, 32'd1);
      @(negedge clk);
      @(negedge clk);

`ifdef OUTPUT_DRAIN_TIMEOUT_EN
      // Stall watchdog on an empty FIFO.
      pulse_start(16'd4);
      cyc = 0;
      while (!done && cyc < 60) begin
         @(negedge clk);
         cyc++;
      end
      check("t7_done", {31'd0, done},        32'd1);
      check("t7_tmo",  {31'd0, timeout_err}, 32'd1);
      @(negedge clk);
      check("t7_sticky", {31'd0, timeout_err}, 32'd1);
      pulse_start(16'd0);
      check("t7_clear", {31'd0, timeout_err}, 32'd0);
      @(negedge clk);
`else
      check("t7_tmo_tied", {31'd0, timeout_err}, 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
